// File: rtl/interpolation_pipe.sv
// interpolation_pipe: 3-stage MRELBP neighbour sampler (axial pass-through, bilinear diagonals).
// Define INTERP_ROUND_EN to round diagonal outputs to the nearest integer (half up, saturating) in stage 3.
module interpolation_pipe #(
    parameter int WIDTH     = 8,
    parameter int FRAC      = 8,
    parameter int RADIUS    = 2,
    parameter int DIAG_INT  = 1,
    parameter int DIAG_FRAC = 106
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic                                             i_valid,
    output logic                                             o_ready,
    input  logic [(2*RADIUS+1)*(2*RADIUS+1)*WIDTH-1:0]       i_window,
    output logic                                             o_valid,
    input  logic                                             i_ready,
    output logic [WIDTH-1:0]                                 o_pixel_center,
    output logic [8*(WIDTH+FRAC)-1:0]                        o_q_ne
);
    localparam int N  = 2*RADIUS+1;
    localparam int QW = WIDTH+FRAC;
    localparam logic [FRAC-1:0] FW = FRAC'(DIAG_FRAC);

    if (RADIUS < 1 || DIAG_INT + 1 > RADIUS || DIAG_FRAC < 0 || DIAG_FRAC >= (1 << FRAC)) begin : g_bad_param
        $error("interpolation_pipe: invalid RADIUS/DIAG_INT/DIAG_FRAC");
    end

    function automatic logic [WIDTH-1:0] px(input logic [N*N*WIDTH-1:0] w, input int r, input int c);
        return w[(r*N+c)*WIDTH +: WIDTH];
    endfunction

    function automatic logic [QW-1:0] hlerp(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] m);
        logic signed [QW+1:0] a, b, c, w;
        a = {2'b00, n, {FRAC{1'b0}}};
        b = {{(FRAC+2){1'b0}}, m};
        c = {{(FRAC+2){1'b0}}, n};
        w = {{(WIDTH+2){1'b0}}, FW};
        return QW'(a + w * (b - c));
    endfunction

    function automatic logic [QW-1:0] vlerp(input logic [QW-1:0] n, input logic [QW-1:0] m);
        logic signed [QW+FRAC+1:0] a, b, c, w;
        a = {2'b00, n, {FRAC{1'b0}}};
        b = {{(FRAC+2){1'b0}}, m};
        c = {{(FRAC+2){1'b0}}, n};
        w = {{(QW+2){1'b0}}, FW};
        return QW'((a + w * (b - c)) >>> FRAC);
    endfunction

`ifdef INTERP_ROUND_EN
    localparam logic [QW:0] HALF = (QW+1)'(1) << (FRAC-1);
    function automatic logic [QW-1:0] rnd(input logic [QW-1:0] q);
        logic [WIDTH:0] ip;
        ip = (WIDTH+1)'(({1'b0, q} + HALF) >> FRAC);
        return {ip[WIDTH] ? {WIDTH{1'b1}} : ip[WIDTH-1:0], {FRAC{1'b0}}};
    endfunction
`endif

    logic                       v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [WIDTH-1:0]           c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [3:0][WIDTH-1:0]      ax1_q, ax1_d, ax2_q, ax2_d;
    logic [3:0][QW-1:0]         hn1_q, hn1_d, hm1_q, hm1_d, dg2_q, dg2_d;
    logic [7:0][QW-1:0]         q3_q, q3_d;
    logic [3:0][QW-1:0]         hn_w, hm_w, dg_w, rd_w;
    logic                       stall, en1, en2, take;

    // Diagonal j drives q_(2j+1); signs (sr,sc) = (+,+), (+,-), (-,-), (-,+).
    for (genvar j = 0; j < 4; j++) begin : g_diag
        localparam int SR = (j < 2) ? 1 : -1;
        localparam int SC = (j == 0 || j == 3) ? 1 : -1;
        localparam int RN = RADIUS + SR*DIAG_INT;
        localparam int RM = RADIUS + SR*(DIAG_INT+1);
        localparam int CN = RADIUS + SC*DIAG_INT;
        localparam int CM = RADIUS + SC*(DIAG_INT+1);
        assign hn_w[j] = hlerp(px(i_window, RN, CN), px(i_window, RN, CM));
        assign hm_w[j] = hlerp(px(i_window, RM, CN), px(i_window, RM, CM));
        assign dg_w[j] = vlerp(hn1_q[j], hm1_q[j]);
`ifdef INTERP_ROUND_EN
        assign rd_w[j] = rnd(dg2_q[j]);
`else
        assign rd_w[j] = dg2_q[j];
`endif
    end

    // A stage advances when the one after it advances or when it holds a bubble.
    always_comb begin
        stall = v3_q && !i_ready;
        o_ready = !stall;
        en2 = !stall || !v2_q;
        en1 = en2 || !v1_q;
        take = i_valid && o_ready;
        v1_d = v1_q;
        c1_d = c1_q;
        ax1_d = ax1_q;
        hn1_d = hn1_q;
        hm1_d = hm1_q;
        v2_d = v2_q;
        c2_d = c2_q;
        ax2_d = ax2_q;
        dg2_d = dg2_q;
        v3_d = v3_q;
        c3_d = c3_q;
        q3_d = q3_q;
        if (en1) v1_d = take;
        if (en1 && take) begin
            c1_d = px(i_window, RADIUS, RADIUS);
            ax1_d[0] = px(i_window, RADIUS, 2*RADIUS);
            ax1_d[1] = px(i_window, 2*RADIUS, RADIUS);
            ax1_d[2] = px(i_window, RADIUS, 0);
            ax1_d[3] = px(i_window, 0, RADIUS);
            hn1_d = hn_w;
            hm1_d = hm_w;
        end
        if (en2) v2_d = v1_q;
        if (en2 && v1_q) begin
            c2_d = c1_q;
            ax2_d = ax1_q;
            dg2_d = dg_w;
        end
        if (!stall) v3_d = v2_q;
        if (!stall && v2_q) begin
            c3_d = c2_q;
            q3_d[0] = {ax2_q[0], {FRAC{1'b0}}};
            q3_d[1] = rd_w[0];
            q3_d[2] = {ax2_q[1], {FRAC{1'b0}}};
            q3_d[3] = rd_w[1];
            q3_d[4] = {ax2_q[2], {FRAC{1'b0}}};
            q3_d[5] = rd_w[2];
            q3_d[6] = {ax2_q[3], {FRAC{1'b0}}};
            q3_d[7] = rd_w[3];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            c1_q <= '0;
            c2_q <= '0;
            c3_q <= '0;
            ax1_q <= '0;
            ax2_q <= '0;
            hn1_q <= '0;
            hm1_q <= '0;
            dg2_q <= '0;
            q3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            c1_q <= c1_d;
            c2_q <= c2_d;
            c3_q <= c3_d;
            ax1_q <= ax1_d;
            ax2_q <= ax2_d;
            hn1_q <= hn1_d;
            hm1_q <= hm1_d;
            dg2_q <= dg2_d;
            q3_q <= q3_d;
        end
    end

    assign o_valid = v3_q;
    assign o_pixel_center = c3_q;
    assign o_q_ne = q3_q;
endmodule

// File: tb/tb_interpolation_pipe.sv
// tb_interpolation_pipe: scoreboard bench for interpolation_pipe (default f=106 and a second f=255 instance).
module tb_interpolation_pipe;
    localparam int NW = 200;
`ifdef INTERP_ROUND_EN
    localparam int Q1 = 8704, Q5 = 1536;
`else
    localparam int Q1 = 8740, Q5 = 1500;
`endif

    typedef struct {
        logic [7:0]   c;
        logic [127:0] q;
        logic [127:0] q2;
    } exp_t;

    logic           clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_ready = 1'b1;
    logic [NW-1:0]  i_window = '0;
    logic           o_ready, o_valid, o_ready2, o_valid2;
    logic [7:0]     o_c, o_c2;
    logic [127:0]   o_q, o_q2;
    exp_t           sb[$];
    exp_t           mon_e;
    int             checks = 0, errors = 0;

    interpolation_pipe u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_window(i_window),
        .o_valid(o_valid), .i_ready(i_ready), .o_pixel_center(o_c), .o_q_ne(o_q)
    );
    interpolation_pipe #(.DIAG_FRAC(255)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready2), .i_window(i_window),
        .o_valid(o_valid2), .i_ready(i_ready), .o_pixel_center(o_c2), .o_q_ne(o_q2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mpx(input logic [NW-1:0] w, input int r, input int c);
        return int'(w[(r*5+c)*8 +: 8]);
    endfunction

    function automatic logic [127:0] model(input logic [NW-1:0] w, input int f);
        logic [127:0] r;
        int sr, sc, rn, rm, cn, cm, hn, hm, v;
        r = '0;
        r[0*16 +: 16] = 16'(mpx(w, 2, 4) << 8);
        r[2*16 +: 16] = 16'(mpx(w, 4, 2) << 8);
        r[4*16 +: 16] = 16'(mpx(w, 2, 0) << 8);
        r[6*16 +: 16] = 16'(mpx(w, 0, 2) << 8);
        for (int j = 0; j < 4; j++) begin
            sr = (j < 2) ? 1 : -1;
            sc = (j == 0 || j == 3) ? 1 : -1;
            rn = 2 + sr; rm = 2 + 2*sr; cn = 2 + sc; cm = 2 + 2*sc;
            hn = mpx(w, rn, cn)*256 + f*(mpx(w, rn, cm) - mpx(w, rn, cn));
            hm = mpx(w, rm, cn)*256 + f*(mpx(w, rm, cm) - mpx(w, rm, cn));
            v = (hn*256 + f*(hm - hn)) >>> 8;
`ifdef INTERP_ROUND_EN
            v = (v + 128) >>> 8;
            if (v > 255) v = 255;
            v = v << 8;
`endif
            r[(2*j+1)*16 +: 16] = 16'(v);
        end
        return r;
    endfunction

    function automatic logic [127:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic logic [NW-1:0] flat(input int v);
        logic [NW-1:0] w;
        for (int k = 0; k < 25; k++) w[k*8 +: 8] = 8'(v);
        return w;
    endfunction

    function automatic logic [NW-1:0] ramp();
        logic [NW-1:0] w;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) w[(r*5+c)*8 +: 8] = 8'(10*c);
        return w;
    endfunction

    function automatic exp_t mk(input logic [NW-1:0] w, input logic [127:0] q);
        exp_t e;
        e.c = 8'(mpx(w, 2, 2));
        e.q = q;
        e.q2 = model(w, 255);
        return e;
    endfunction

    task automatic drive(input logic [NW-1:0] w, input exp_t e);
        int n;
        i_valid = 1'b1;
        i_window = w;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (o_ready) begin
                sb.push_back(e);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 100) begin
                chk("drive_timeout", 1, 0);
                break;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", o_q, 0);
                if (o_q == 0) chk("unexpected_output_valid", {127'b0, o_valid}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("center", {120'b0, o_c}, {120'b0, mon_e.c});
                chk("q_ne", o_q, mon_e.q);
                chk("q_ne_f255", o_q2, mon_e.q2);
                chk("center_f255", {120'b0, o_c2}, {120'b0, mon_e.c});
                chk("valid_f255", {127'b0, o_valid2}, 1);
            end
        end
    end

    initial begin
        logic [127:0] snap;
        logic [NW-1:0] w;
        logic sent, stayed;
        int n;
        idle(3);
        rst = 1'b0;
        chk("reset_valid", {127'b0, o_valid}, 0);
        chk("reset_q", o_q, 0);
        chk("reset_center", {120'b0, o_c}, 0);
        chk("reset_ready", {127'b0, o_ready}, 1);

        drive(flat(100), mk(flat(100), pk(25600, 25600, 25600, 25600, 25600, 25600, 25600, 25600)));
        idle(1);
        chk("latency_early", {127'b0, o_valid}, 0);
        idle(1);
        chk("latency_3", {127'b0, o_valid}, 1);
        idle(3);

        drive(ramp(), mk(ramp(), pk(10240, Q1, 5120, Q5, 0, Q5, 5120, Q1)));
        idle(5);

        for (int v = 1; v <= 4; v++) drive(flat(v), mk(flat(v), pk(256*v, 256*v, 256*v, 256*v, 256*v, 256*v, 256*v, 256*v)));
        i_ready = 1'b0;
        idle(1);
        snap = o_q;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", {127'b0, o_valid}, 1);
            chk("stall_ready", {127'b0, o_ready}, 0);
            chk("stall_stable", o_q, snap);
            idle(1);
        end
        i_ready = 1'b1;
        idle(6);
        chk("stall_drained", 128'(sb.size()), 0);

        drive(flat(7), mk(flat(7), pk(1792, 1792, 1792, 1792, 1792, 1792, 1792, 1792)));
        drive(flat(9), mk(flat(9), pk(2304, 2304, 2304, 2304, 2304, 2304, 2304, 2304)));
        rst = 1'b1;
        sb.delete();
        idle(1);
        rst = 1'b0;
        chk("rst_mid_valid", {127'b0, o_valid}, 0);
        chk("rst_mid_q", o_q, 0);
        stayed = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (o_valid) stayed = 1'b0;
            idle(1);
        end
        chk("rst_mid_quiet", {127'b0, stayed}, 1);

        drive(flat(255), mk(flat(255), pk(65280, 65280, 65280, 65280, 65280, 65280, 65280, 65280)));
        idle(5);

        for (int i = 0; i < 3000; i++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            if (!i_valid && $urandom_range(0, 2) != 0) begin
                for (int k = 0; k < 25; k++) w[k*8 +: 8] = 8'($urandom);
                i_valid = 1'b1;
                i_window = w;
            end
            @(negedge clk);
            sent = i_valid && o_ready;
            if (sent) sb.push_back(mk(i_window, model(i_window, 106)));
            @(posedge clk); #1;
            if (sent) i_valid = 1'b0;
        end
        i_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin idle(1); n++; end
        chk("final_drain", 128'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
